// File: rtl/sync_tdp_ram_be.sv
// sync_tdp_ram_be: true dual-port byte-enable RAM with collision tracking; optional zeroing scrub via SYNC_TDP_RAM_INIT_SCRUB_EN
module sync_tdp_ram_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REGS   = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic                    CSelA_SI,
  input  logic                    WrEnA_SI,
  input  logic [DATA_WIDTH/8-1:0] BeA_SI,
  input  logic [DATA_WIDTH-1:0]   WrDataA_DI,
  input  logic [ADDR_WIDTH-1:0]   AddrA_DI,
  output logic [DATA_WIDTH-1:0]   RdDataA_DO,
  output logic                    RdValidA_SO,
  input  logic                    CSelB_SI,
  input  logic                    WrEnB_SI,
  input  logic [DATA_WIDTH/8-1:0] BeB_SI,
  input  logic [DATA_WIDTH-1:0]   WrDataB_DI,
  input  logic [ADDR_WIDTH-1:0]   AddrB_DI,
  output logic [DATA_WIDTH-1:0]   RdDataB_DO,
  output logic                    RdValidB_SO,
  output logic                    Busy_SO,
  output logic                    CollErr_SO,
  output logic [15:0]             CollCnt_DO
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DATA_DEPTH > 1 ? $clog2(DATA_DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic acc_a, acc_b, in_a, in_b, same, coll, rsp_a, rsp_b, scrub;
  logic [IW-1:0] scrub_addr;
  logic [NB-1:0] wa, wb;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, d1_a, d1_b;
  logic [1:0] v1;
  assign acc_a = CSelA_SI && !Busy_SO && Rst_RBI;
  assign acc_b = CSelB_SI && !Busy_SO && Rst_RBI;
  assign in_a = 32'(AddrA_DI) < DATA_DEPTH;
  assign in_b = 32'(AddrB_DI) < DATA_DEPTH;
  assign same = AddrA_DI == AddrB_DI;
  assign old_a = in_a ? mem[AddrA_DI[IW-1:0]] : '0;
  assign old_b = in_b ? mem[AddrB_DI[IW-1:0]] : '0;
  assign wa = (acc_a && WrEnA_SI && in_a) ? BeA_SI : '0;
  assign wb = (acc_b && WrEnB_SI && in_b) ? BeB_SI & ~((acc_a && WrEnA_SI && same) ? BeA_SI : '0) : '0;
  assign coll = acc_a && WrEnA_SI && acc_b && WrEnB_SI && same && |(BeA_SI & BeB_SI);
  assign rsp_a = acc_a && (!WrEnA_SI || RDW_MODE == 1);
  assign rsp_b = acc_b && (!WrEnB_SI || RDW_MODE == 1);
  // post-write word as seen by each port, including the other port's lanes at the same address
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      new_a[8*i +: 8] = wa[i] ? WrDataA_DI[8*i +: 8] : (same && wb[i]) ? WrDataB_DI[8*i +: 8] : old_a[8*i +: 8];
      new_b[8*i +: 8] = wb[i] ? WrDataB_DI[8*i +: 8] : (same && wa[i]) ? WrDataA_DI[8*i +: 8] : old_b[8*i +: 8];
    end
  end
  // storage: scrub zeroing and byte-lane writes; B lanes already masked where A wins
  always_ff @(posedge Clk_CI) begin
    if (scrub) mem[scrub_addr] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (wa[i]) mem[AddrA_DI[IW-1:0]][8*i +: 8] <= WrDataA_DI[8*i +: 8];
      if (wb[i]) mem[AddrB_DI[IW-1:0]][8*i +: 8] <= WrDataB_DI[8*i +: 8];
    end
  end
  // first read stage: read-first word for reads, merged word for write-first writes
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      v1 <= '0;
      d1_a <= '0;
      d1_b <= '0;
    end else begin
      v1 <= {rsp_b, rsp_a};
      if (rsp_a) d1_a <= WrEnA_SI ? new_a : old_a;
      if (rsp_b) d1_b <= WrEnB_SI ? new_b : old_b;
    end
  end
  if (OUT_REGS == 1) begin : g_oreg
    // optional output stage; data holds while no read completes
    always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
        RdValidA_SO <= 1'b0;
        RdValidB_SO <= 1'b0;
        RdDataA_DO <= '0;
        RdDataB_DO <= '0;
      end else begin
        RdValidA_SO <= v1[0];
        RdValidB_SO <= v1[1];
        if (v1[0]) RdDataA_DO <= d1_a;
        if (v1[1]) RdDataB_DO <= d1_b;
      end
    end
  end else begin : g_noreg
    assign RdValidA_SO = v1[0];
    assign RdValidB_SO = v1[1];
    assign RdDataA_DO = d1_a;
    assign RdDataB_DO = d1_b;
  end
  // collision pulse and saturating collision counter
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      CollErr_SO <= 1'b0;
      CollCnt_DO <= '0;
    end else begin
      CollErr_SO <= coll;
      if (coll && CollCnt_DO != 16'hFFFF) CollCnt_DO <= CollCnt_DO + 16'd1;
    end
  end
`ifdef SYNC_TDP_RAM_INIT_SCRUB_EN
  typedef enum logic [1:0] {IDLE, SCRUB, READY} state_e;
  state_e state, state_nx;
  // scrub state and address registers; reset restarts from address 0
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state <= IDLE;
      scrub_addr <= '0;
    end else begin
      state <= state_nx;
      scrub_addr <= scrub ? scrub_addr + 1'b1 : '0;
    end
  end
  // scrub sequencing: start on reset release, finish after the last word
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? SCRUB : (state == SCRUB && scrub_addr == IW'(DATA_DEPTH - 1)) ? READY : state;
  end
  assign scrub = state == SCRUB;
  assign Busy_SO = state != READY;
`else
  assign scrub = 1'b0;
  assign scrub_addr = '0;
  assign Busy_SO = 1'b0;
`endif
endmodule

// File: tb/tb_sync_tdp_ram_be.sv
// tb_sync_tdp_ram_be: scoreboard bench for two RAM configurations driven in lockstep
module tb_sync_tdp_ram_be;
  localparam int AW = 7;
  localparam int DEPTH = 100;
`ifdef SYNC_TDP_RAM_INIT_SCRUB_EN
  localparam int EXP_BUSY = DEPTH;
`else
  localparam int EXP_BUSY = 0;
`endif
  typedef struct {int unsigned cyc; logic [31:0] d;} exp_t;
  logic clk = 1'b0, rst_n;
  logic cs_a, we_a, cs_b, we_b;
  logic [3:0] be_a, be_b;
  logic [31:0] wd_a, wd_b;
  logic [AW-1:0] ad_a, ad_b;
  logic [31:0] rdata [2][2];
  logic rvalid [2][2];
  logic busy [2];
  logic collerr [2];
  logic [15:0] collcnt [2];
  exp_t rq [2][2][$];
  int unsigned cq [2][$];
  logic [15:0] ccnt [2];
  logic [31:0] last [2][2];
  logic [31:0] mm [DEPTH];
  int unsigned cyc = 0;
  int n_cmp = 0, n_err = 0;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sync_tdp_ram_be #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(32), .OUT_REGS(0), .RDW_MODE(0)) dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .CSelA_SI(cs_a), .WrEnA_SI(we_a), .BeA_SI(be_a), .WrDataA_DI(wd_a), .AddrA_DI(ad_a),
    .RdDataA_DO(rdata[0][0]), .RdValidA_SO(rvalid[0][0]),
    .CSelB_SI(cs_b), .WrEnB_SI(we_b), .BeB_SI(be_b), .WrDataB_DI(wd_b), .AddrB_DI(ad_b),
    .RdDataB_DO(rdata[0][1]), .RdValidB_SO(rvalid[0][1]),
    .Busy_SO(busy[0]), .CollErr_SO(collerr[0]), .CollCnt_DO(collcnt[0]));
  sync_tdp_ram_be #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(32), .OUT_REGS(1), .RDW_MODE(1)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .CSelA_SI(cs_a), .WrEnA_SI(we_a), .BeA_SI(be_a), .WrDataA_DI(wd_a), .AddrA_DI(ad_a),
    .RdDataA_DO(rdata[1][0]), .RdValidA_SO(rvalid[1][0]),
    .CSelB_SI(cs_b), .WrEnB_SI(we_b), .BeB_SI(be_b), .WrDataB_DI(wd_b), .AddrB_DI(ad_b),
    .RdDataB_DO(rdata[1][1]), .RdValidB_SO(rvalid[1][1]),
    .Busy_SO(busy[1]), .CollErr_SO(collerr[1]), .CollCnt_DO(collcnt[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rdm(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? mm[a] : 32'h0;
  endfunction

  task automatic wr_model(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    if (int'(a) < DEPTH)
      for (int i = 0; i < 4; i++)
        if (be[i]) mm[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cs_a = 0; we_a = 0; be_a = 0; wd_a = 0; ad_a = 0;
    cs_b = 0; we_b = 0; be_b = 0; wd_b = 0; ad_b = 0;
  endtask

  // drive one cycle on both ports and record what the spec says must come back
  task automatic issue(input logic ca, input logic wea, input logic [3:0] ba, input logic [31:0] da, input logic [AW-1:0] aa,
                       input logic cb, input logic web, input logic [3:0] bb, input logic [31:0] db, input logic [AW-1:0] ab);
    logic [31:0] olda, oldb;
    cs_a = ca; we_a = wea; be_a = ba; wd_a = da; ad_a = aa;
    cs_b = cb; we_b = web; be_b = bb; wd_b = db; ad_b = ab;
    olda = rdm(aa);
    oldb = rdm(ab);
    if (cb && web) wr_model(ab, bb, db);
    if (ca && wea) wr_model(aa, ba, da);
    if (ca && wea && cb && web && aa == ab && (ba & bb) != 0) begin
      cq[0].push_back(cyc + 1);
      cq[1].push_back(cyc + 1);
    end
    if (ca && !wea) begin
      rq[0][0].push_back('{cyc + 1, olda});
      rq[1][0].push_back('{cyc + 2, olda});
    end
    if (ca && wea) rq[1][0].push_back('{cyc + 2, rdm(aa)});
    if (cb && !web) begin
      rq[0][1].push_back('{cyc + 1, oldb});
      rq[1][1].push_back('{cyc + 2, oldb});
    end
    if (cb && web) rq[1][1].push_back('{cyc + 2, rdm(ab)});
    tick();
    idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (busy[0] && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    logic ev;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        ev = rq[d][p].size() > 0 && rq[d][p][0].cyc == cyc;
        chk($sformatf("valid d%0d p%0d", d, p), 32'(rvalid[d][p]), 32'(ev));
        if (ev) begin
          chk($sformatf("rdata d%0d p%0d", d, p), rdata[d][p], rq[d][p][0].d);
          last[d][p] = rq[d][p][0].d;
          void'(rq[d][p].pop_front());
        end else chk($sformatf("hold d%0d p%0d", d, p), rdata[d][p], last[d][p]);
      end
      ev = cq[d].size() > 0 && cq[d][0] == cyc;
      chk($sformatf("coll_err d%0d", d), 32'(collerr[d]), 32'(ev));
      if (ev) begin
        void'(cq[d].pop_front());
        if (ccnt[d] != 16'hFFFF) ccnt[d] = ccnt[d] + 16'd1;
      end
      chk($sformatf("coll_cnt d%0d", d), 32'(collcnt[d]), 32'(ccnt[d]));
    end
  end

  initial begin
    int n;
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    for (int d = 0; d < 2; d++) begin
      ccnt[d] = 16'h0;
      last[d][0] = 32'h0;
      last[d][1] = 32'h0;
    end
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst rdata_a d%0d", d), rdata[d][0], 32'h0);
      chk($sformatf("rst rdata_b d%0d", d), rdata[d][1], 32'h0);
      chk($sformatf("rst valid_a d%0d", d), 32'(rvalid[d][0]), 32'h0);
      chk($sformatf("rst valid_b d%0d", d), 32'(rvalid[d][1]), 32'h0);
      chk($sformatf("rst coll_err d%0d", d), 32'(collerr[d]), 32'h0);
      chk($sformatf("rst coll_cnt d%0d", d), 32'(collcnt[d]), 32'h0);
    end
    mon_en = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef SYNC_TDP_RAM_INIT_SCRUB_EN
    cs_a = 1; we_a = 1; be_a = 4'hF; wd_a = 32'hFFFFFFFF; ad_a = '0;
    cs_b = 1; we_b = 0; ad_b = 7'd1;
`endif
    count_busy(n);
    idle();
    chk("busy_cycles", 32'(n), 32'(EXP_BUSY));
    chk("busy_after d1", 32'(busy[1]), 32'h0);
    tick();
`ifndef SYNC_TDP_RAM_INIT_SCRUB_EN
    for (int i = 0; i < DEPTH; i++) issue(1, 1, 4'hF, $urandom, AW'(i), 0, 0, 4'h0, 32'h0, '0);
`endif
    for (int i = 0; i < 1500; i++) begin
      a = AW'($urandom_range(0, 127));
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), $urandom, a,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
            $urandom_range(0, 3) == 0 ? a : AW'($urandom_range(0, 127)));
    end
    issue(1, 1, 4'hF, 32'hDEADBEEF, 7'h10, 0, 0, 4'h0, 32'h0, '0);
    issue(0, 0, 4'h0, 32'h0, '0, 1, 0, 4'h0, 32'h0, 7'h10);
    issue(1, 1, 4'hF, 32'h11223344, 7'h20, 0, 0, 4'h0, 32'h0, '0);
    issue(1, 1, 4'b0101, 32'hAABBCCDD, 7'h20, 0, 0, 4'h0, 32'h0, '0);
    issue(0, 0, 4'h0, 32'h0, '0, 1, 0, 4'h0, 32'h0, 7'h20);
    issue(0, 0, 4'h0, 32'h0, '0, 1, 1, 4'h0, 32'h12345678, 7'h20);
    issue(1, 0, 4'h0, 32'h0, 7'h20, 0, 0, 4'h0, 32'h0, '0);
    issue(1, 1, 4'hF, 32'h0, 7'h30, 1, 1, 4'hF, 32'hFFFFFFFF, 7'h30);
    issue(0, 0, 4'h0, 32'h0, '0, 1, 0, 4'h0, 32'h0, 7'h30);
    issue(1, 1, 4'hF, 32'h5A5A5A5A, 7'h11, 0, 0, 4'h0, 32'h0, '0);
    issue(1, 1, 4'hF, 32'hCAFEF00D, 7'h40, 1, 0, 4'h0, 32'h0, 7'h40);
    issue(1, 1, 4'hF, 32'hFFFFFFFF, 7'd100, 1, 1, 4'hF, 32'hFFFFFFFF, 7'd127);
    issue(1, 0, 4'h0, 32'h0, 7'd100, 1, 0, 4'h0, 32'h0, 7'd127);
    issue(1, 0, 4'h0, 32'h0, 7'd99, 1, 0, 4'h0, 32'h0, 7'd0);
    for (int i = 0; i < 65540; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      issue(1, 1, 4'($urandom) | 4'h1, $urandom, a, 1, 1, 4'($urandom) | 4'h1, $urandom, a);
    end
    repeat (5) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("sat coll_cnt d%0d", d), 32'(collcnt[d]), 32'h0000FFFF);
      chk($sformatf("drain coll d%0d", d), 32'(cq[d].size()), 32'h0);
      for (int p = 0; p < 2; p++) chk($sformatf("drain rd d%0d p%0d", d, p), 32'(rq[d][p].size()), 32'h0);
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
